// File: rtl/proc7_pkg.sv
// Shared definitions for the 7-bit processor control stage: widths, opcode and
// state encodings, and instruction field extraction.
package proc7_pkg;

  localparam int DATA_W = 7;
  localparam int NREG   = 4;

  typedef enum logic [1:0] {
    OP_MV  = 2'b00,
    OP_MVI = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } state_e;

  function automatic op_e get_op(input logic [DATA_W-1:0] w);
    return op_e'(w[6:5]);
  endfunction

  function automatic logic [1:0] get_rx(input logic [DATA_W-1:0] w);
    return w[4:3];
  endfunction

  function automatic logic [1:0] get_ry(input logic [DATA_W-1:0] w);
    return w[2:1];
  endfunction

endpackage

// File: rtl/proc7_ctrl_if.sv
// Instruction handshake plus the operand/result bus to the external adder.
// master = processor top (feeds instructions, owns the adder), slave = proc7_ctrl.
interface proc7_ctrl_if;

  logic                         run;
  logic [proc7_pkg::DATA_W-1:0] din;
  logic                         done;
  logic                         busy;
  logic [proc7_pkg::DATA_W-1:0] add_a;
  logic [proc7_pkg::DATA_W-1:0] add_b;
  logic                         add_ci;
  logic [proc7_pkg::DATA_W-1:0] add_s;
  logic                         add_co;

  modport master (
    output run, din, add_s, add_co,
    input  done, busy, add_a, add_b, add_ci
  );

  modport slave (
    input  run, din, add_s, add_co,
    output done, busy, add_a, add_b, add_ci
  );

endinterface

// File: rtl/regfile4x7.sv
// Four 7-bit general registers: one synchronous write port, combinational
// rx/ry operand reads and a debug read, all cleared by reset.
module regfile4x7
  import proc7_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [1:0]        rx_addr,
  input  logic [1:0]        ry_addr,
  input  logic [1:0]        dbg_addr,
  output logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] ry_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NREG-1:0][DATA_W-1:0] regs_q;
  logic [NREG-1:0][DATA_W-1:0] regs_d;

  // Next register contents: at most one register changes per cycle.
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register storage with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rx_data  = regs_q[rx_addr];
  assign ry_data  = regs_q[ry_addr];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/proc7_ctrl.sv
// Multi-cycle control stage: T0 fetch, T1 move/latch operand, T2 drive the
// external adder and capture result/flags, T3 write back.
module proc7_ctrl
  import proc7_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  proc7_ctrl_if.slave       bus,
  output logic              cy_flag,
  output logic              z_flag,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              ci_q, ci_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic              cy_q, cy_d;
  logic              z_q, z_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              we_s;
  logic [DATA_W-1:0] wdata_s;
  logic [DATA_W-1:0] rx_data_s;
  logic [DATA_W-1:0] ry_data_s;
  logic              ir_unused_s;

  assign ir_unused_s = ir_q[0];

  regfile4x7 u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (we_s),
    .waddr    (get_rx(ir_q)),
    .wdata    (wdata_s),
    .rx_addr  (get_rx(ir_q)),
    .ry_addr  (get_ry(ir_q)),
    .dbg_addr (dbg_sel),
    .rx_data  (rx_data_s),
    .ry_data  (ry_data_s),
    .dbg_data (dbg_data)
  );

  // Next-state, datapath and output decode. Adder operands are loaded on the
  // T1->T2 edge so they appear registered in T2 and fall back to 0 elsewhere;
  // done is likewise pre-decoded one edge early so it is a flop output.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    a_d     = '0;
    b_d     = '0;
    ci_d    = 1'b0;
    g_d     = g_q;
    cy_d    = cy_q;
    z_d     = z_q;
    done_d  = 1'b0;
    we_s    = 1'b0;
    wdata_s = '0;
    case (state_q)
      T0: begin
        if (bus.run) begin
          ir_d    = bus.din;
          state_d = T1;
          done_d  = (get_op(bus.din) == OP_MV) || (get_op(bus.din) == OP_MVI);
        end else begin
          state_d = T0;
        end
      end
      T1: begin
        case (get_op(ir_q))
          OP_MV: begin
            we_s    = 1'b1;
            wdata_s = ry_data_s;
            state_d = T0;
          end
          OP_MVI: begin
            we_s    = 1'b1;
            wdata_s = bus.din;
            state_d = T0;
          end
          OP_ADD, OP_SUB: begin
            a_d     = rx_data_s;
            b_d     = ry_data_s;
            ci_d    = (get_op(ir_q) == OP_SUB);
            state_d = T2;
          end
          default: state_d = T0;
        endcase
      end
      T2: begin
        g_d     = bus.add_s;
        cy_d    = bus.add_co;
        z_d     = (bus.add_s == 7'd0);
        done_d  = 1'b1;
        state_d = T3;
      end
      T3: begin
        we_s    = 1'b1;
        wdata_s = g_q;
        state_d = T0;
      end
      default: state_d = T0;
    endcase
    busy_d = (state_d != T0);
  end

  // State and control/datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= T0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ci_q    <= 1'b0;
      g_q     <= '0;
      cy_q    <= 1'b0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ci_q    <= ci_d;
      g_q     <= g_d;
      cy_q    <= cy_d;
      z_q     <= z_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.add_a  = a_q;
  assign bus.add_b  = b_q;
  assign bus.add_ci = ci_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign cy_flag    = cy_q;
  assign z_flag     = z_q;

endmodule

// File: tb/tb_proc7_ctrl.sv
// Directed + randomized bench for proc7_ctrl against an instruction-level
// model of the register file and flags, with a behavioural adder attached.
module tb_proc7_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cy_flag, z_flag;
  logic [1:0] dbg_sel;
  logic [6:0] dbg_data;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int r [4];
  bit mcy, mz;

  proc7_ctrl_if bus ();

  proc7_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cy_flag  (cy_flag),
    .z_flag   (z_flag),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  always #5 clk = ~clk;

  // External adder/subtractor: A + (ci ? ~B : B) + ci.
  assign {bus.add_co, bus.add_s} = {1'b0, bus.add_a}
                                 + {1'b0, (bus.add_ci ? ~bus.add_b : bus.add_b)}
                                 + {7'b0, bus.add_ci};

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s_R%0d", tag, i), {1'b0, dbg_data}, 8'(r[i]));
    end
    chk({tag, "_cy"}, {7'b0, cy_flag}, {7'b0, mcy});
    chk({tag, "_z"},  {7'b0, z_flag},  {7'b0, mz});
  endtask

  task automatic idle(input int n);
    bus.run = 1'b0;
    bus.din = 7'($urandom);
    repeat (n) begin
      tick();
      chk("idle_done", {7'b0, bus.done}, 8'd0);
      chk("idle_busy", {7'b0, bus.busy}, 8'd0);
    end
  endtask

  // Issue one instruction in the current T0 cycle and follow it to retirement.
  task automatic exec(input int op, input int rx, input int ry, input int imm, input bit hold);
    int res;
    chk("t0_busy", {7'b0, bus.busy}, 8'd0);
    bus.din = {2'(op), 2'(rx), 2'(ry), 1'($urandom)};
    bus.run = 1'b1;
    tick();
    chk("c1_busy", {7'b0, bus.busy}, 8'd1);
    if (op < 2) begin
      bus.run = hold;
      bus.din = (op == 1) ? 7'(imm) : 7'($urandom);
      chk("mv_c1_done", {7'b0, bus.done}, 8'd1);
      r[rx] = (op == 1) ? imm : r[ry];
      tick();
    end else begin
      bus.run = hold ? 1'b1 : 1'($urandom);
      bus.din = 7'($urandom);
      chk("alu_c1_done", {7'b0, bus.done}, 8'd0);
      chk("alu_c1_add_a", {1'b0, bus.add_a}, 8'd0);
      tick();
      chk("alu_c2_add_a", {1'b0, bus.add_a}, 8'(r[rx]));
      chk("alu_c2_add_b", {1'b0, bus.add_b}, 8'(r[ry]));
      chk("alu_c2_add_ci", {7'b0, bus.add_ci}, (op == 3) ? 8'd1 : 8'd0);
      chk("alu_c2_done", {7'b0, bus.done}, 8'd0);
      bus.run = hold ? 1'b1 : 1'($urandom);
      bus.din = 7'($urandom);
      if (op == 2) begin
        res = r[rx] + r[ry];
        mcy = (res >= 128);
        res = res % 128;
      end else begin
        mcy = (r[rx] >= r[ry]);
        res = (r[rx] - r[ry] + 128) % 128;
      end
      mz = (res == 0);
      r[rx] = res;
      tick();
      bus.run = hold;
      chk("alu_c3_done", {7'b0, bus.done}, 8'd1);
      chk("alu_c3_busy", {7'b0, bus.busy}, 8'd1);
      chk("alu_c3_cy", {7'b0, cy_flag}, {7'b0, mcy});
      chk("alu_c3_z", {7'b0, z_flag}, {7'b0, mz});
      chk("alu_c3_add_a", {1'b0, bus.add_a}, 8'd0);
      tick();
    end
    chk("after_done", {7'b0, bus.done}, 8'd0);
    check_state("after");
  endtask

  initial begin
    int op, rx, ry, imm;
    bit hold;

    rst     = 1'b1;
    bus.run = 1'b0;
    bus.din = 7'd0;
    dbg_sel = 2'd0;
    foreach (r[i]) r[i] = 0;
    mcy = 1'b0;
    mz  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_done", {7'b0, bus.done}, 8'd0);
    chk("rst_busy", {7'b0, bus.busy}, 8'd0);
    chk("rst_add_a", {1'b0, bus.add_a}, 8'd0);
    chk("rst_add_b", {1'b0, bus.add_b}, 8'd0);
    chk("rst_add_ci", {7'b0, bus.add_ci}, 8'd0);
    check_state("rst");

    // MVI R1,0x15 ; MV R2,R1
    exec(1, 1, 0, 'h15, 1'b0);
    exec(0, 2, 1, 0, 1'b0);
    idle(2);

    // 0x7F + 0x01 wraps to zero with carry
    exec(1, 0, 0, 'h7F, 1'b0);
    exec(1, 1, 0, 'h01, 1'b0);
    exec(2, 0, 1, 0, 1'b0);

    // 3 - 5 borrows; R3 - R3 is zero without borrow
    exec(1, 2, 0, 'h03, 1'b0);
    exec(1, 3, 0, 'h05, 1'b0);
    exec(3, 2, 3, 0, 1'b0);
    exec(3, 3, 3, 0, 1'b0);
    idle(1);

    // run held high through an ADD, MVI, ADD stream
    exec(2, $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b1);
    exec(1, $urandom_range(0, 3), 0, $urandom_range(0, 127), 1'b1);
    exec(2, $urandom_range(0, 3), $urandom_range(0, 3), 0, 1'b0);

    // doubling through ADD Rx,Rx
    exec(1, 1, 0, 'h21, 1'b0);
    exec(2, 1, 1, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op   = $urandom_range(0, 3);
      rx   = $urandom_range(0, 3);
      ry   = $urandom_range(0, 3);
      imm  = $urandom_range(0, 127);
      hold = 1'($urandom);
      exec(op, rx, ry, imm, hold);
      if (!hold) idle($urandom_range(0, 2));
    end
    idle(1);

    // reset in T2 of an ADD aborts it
    exec(1, 0, 0, 'h11, 1'b0);
    bus.din = {2'b10, 2'd0, 2'd0, 1'b0};
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    chk("abort_t2_add_a", {1'b0, bus.add_a}, 8'h11);
    rst = 1'b1;
    tick();
    foreach (r[i]) r[i] = 0;
    mcy = 1'b0;
    mz  = 1'b0;
    chk("abort_done", {7'b0, bus.done}, 8'd0);
    chk("abort_busy", {7'b0, bus.busy}, 8'd0);
    chk("abort_add_a", {1'b0, bus.add_a}, 8'd0);
    chk("abort_add_b", {1'b0, bus.add_b}, 8'd0);
    chk("abort_add_ci", {7'b0, bus.add_ci}, 8'd0);
    check_state("abort");
    rst = 1'b0;
    idle(3);
    check_state("post_abort");

    exec(1, 3, 0, 'h2A, 1'b0);
    exec(2, 3, 3, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/proc7_ctrl.md
# proc7_ctrl

Multi-cycle control and register-file stage of the 7-bit simple processor unit. It accepts instructions and immediates on a 7-bit data input, holds four 7-bit general registers, and sequences ADD/SUB through the external 7-bit adder/subtractor. It drives the adder's A, B and Ci operands and captures its sum and carry-out, so it sits directly upstream and downstream of the arithmetic stage.

## Interface
- DATA_W, 7, datapath width; the instruction encoding requires exactly 7.
- clk  in  1  single clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- run  in  1  start request; sampled only in state T0.
- din  in  7  instruction word in T0; immediate word in T1 of MVI.
- add_a  out  7  adder operand A.
- add_b  out  7  adder operand B.
- add_ci  out  1  adder mode/carry-in: 1 = subtract.
- add_s  in  7  adder sum/difference.
- add_co  in  1  adder carry-out.
- done  out  1  one-cycle pulse when an instruction retires.
- busy  out  1  high in every state except T0.
- cy_flag  out  1  carry flag; last ADD/SUB add_co.
- z_flag  out  1  zero flag; 1 when the last ADD/SUB result was 0.
- dbg_sel  in  2  debug register select.
- dbg_data  out  7  combinational read of R[dbg_sel].

## Operation
- Instruction fields: op = din[6:5] (00 MV, 01 MVI, 10 ADD, 11 SUB), rx = din[4:3], ry = din[2:1]. din[0] is reserved and ignored.
- Internal state: IR (7 bits), R0–R3, hold register A, result register G, cy_flag, z_flag.
- FSM states and transitions:
  - T0: if run = 1, IR <= din and go to T1; otherwise stay.
  - T1, MV: R[rx] <= R[ry], done = 1, go to T0.
  - T1, MVI: R[rx] <= din, done = 1, go to T0.
  - T1, ADD/SUB: A <= R[rx], go to T2.
  - T2: add_a = A, add_b = R[ry], add_ci = IR[5]; G <= add_s, cy_flag <= add_co, z_flag <= (add_s == 0); go to T3.
  - T3: R[rx] <= G, done = 1, go to T0.
- Outside T2, add_a, add_b and add_ci are driven to 0.
- Arithmetic is modulo 2^7. SUB relies on the adder computing A + ~B + 1, so cy_flag = 1 means no borrow.
- Flags change only in T2. MV and MVI leave both flags unchanged.
- rx == ry is legal. MV Rx,Rx is a no-op that still pulses done. ADD Rx,Rx doubles Rx.
- run while busy is ignored and not queued. run held high in the cycle after done starts a new instruction from that cycle's din.
- Reset, including mid-instruction: state T0; R0–R3, IR, A, G = 0; cy_flag, z_flag, done = 0. An aborted instruction never pulses done and never writes a register.

## Timing
- Cycle 0 is the cycle in which run is sampled high in T0.
- MV/MVI: register write and done occur in cycle 1; busy is high in cycle 1 only. The MVI immediate must be valid on din in cycle 1.
- ADD/SUB: adder operands are valid in cycle 2; the adder is purely combinational, and add_s/add_co are sampled at the end of cycle 2. R[rx] is written and done pulses in cycle 3; busy is high in cycles 1–3.
- Register writes are visible on dbg_data the cycle after the write edge.
- Throughput: one MV/MVI every 2 cycles, one ADD/SUB every 4 cycles.

## Structure
- Package proc7_pkg holds: DATA_W, NREG = 4, the opcode enum (OP_MV, OP_MVI, OP_ADD, OP_SUB), the state enum (T0–T3), and field-extract functions for op, rx and ry.
- Sub-module regfile4x7 provides one synchronous write port, two combinational read ports (rx, ry) and a debug read port, with synchronous reset to 0.
- The FSM and the IR, A, G and flag registers live in proc7_ctrl. The adder is instantiated outside, at the processor top level.

## Test plan
- Reset, then MVI R1,0x15 followed by MV R2,R1 -> dbg R1 = 0x15, R2 = 0x15; done in cycle 1 of each instruction; flags stay 0.
- R0 = 0x7F, R1 = 0x01, ADD R0,R1 -> add_a = 0x7F, add_b = 0x01, add_ci = 0 in cycle 2; R0 = 0x00, cy_flag = 1, z_flag = 1; done in cycle 3.
- R2 = 0x03, R3 = 0x05, SUB R2,R3 -> add_ci = 1; R2 = 0x7E, cy_flag = 0, z_flag = 0. Then SUB R3,R3 -> R3 = 0, cy_flag = 1, z_flag = 1.
- run held high continuously with a back-to-back ADD, MVI, ADD stream -> each instruction is accepted in the cycle after the previous done; run during busy is ignored.
- Assert rst in T2 of an ADD -> next cycle state is T0, all registers and flags are 0, no done pulse, and add_a/add_b/add_ci = 0.
- ADD R1,R1 with R1 = 0x21 -> R1 = 0x42; add_a and add_b both 0x21.
